// File: rtl/apb_slave_mem.sv
// APB completer backed by a small register memory, with a fixed number of
// wait states per transfer and error responses for bad or unpowered accesses.
module apb_slave_mem #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 128,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PWAKEUP,
   output logic                  PREADY,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PSLVERR
);

   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [1:0]        WAIT_L  = 2'(WAIT_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state, state_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [IDX_W-1:0]      idx_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;
   logic [1:0]            wcnt, wcnt_d;

   logic                  pready_d, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_d;
   logic                  setup, respond, mem_we;
   logic                  setup_phase, setup_err;
   logic                  r_write, r_err;
   logic [IDX_W-1:0]      r_idx, paddr_idx;

   assign paddr_idx   = PADDR[IDX_W-1:0];
   assign setup_phase = PSEL && !PENABLE;
   assign setup_err   = ({1'b0, PADDR} >= DEPTH_L) || !PWAKEUP;

   always_comb begin
      state_d   = state;
      wcnt_d    = wcnt;
      pready_d  = PREADY;
      pslverr_d = PSLVERR;
      prdata_d  = PRDATA;
      setup     = 1'b0;
      respond   = 1'b0;
      mem_we    = 1'b0;

      unique case (state)
         IDLE: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            if (setup_phase) setup = 1'b1;
         end
         ACCESS: begin
            if (!PSEL) begin
               state_d   = IDLE;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
            end else if (!PENABLE) begin
               setup = 1'b1;
            end else if (!PREADY) begin
               wcnt_d = (wcnt == 2'd0) ? 2'd0 : wcnt - 2'd1;
               if (wcnt <= 2'd1) respond = 1'b1;
            end else begin
               mem_we    = write_q && !err_q;
               state_d   = IDLE;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // A fresh setup (from IDLE or restarting an aborted access) wins over everything else
      if (setup) begin
         state_d   = ACCESS;
         wcnt_d    = WAIT_L;
         pready_d  = 1'b0;
         pslverr_d = 1'b0;
         respond   = (WAIT_L == 2'd0);
      end

      // With zero wait states the response is built from the live setup values
      r_write = setup ? PWRITE    : write_q;
      r_err   = setup ? setup_err : err_q;
      r_idx   = setup ? paddr_idx : idx_q;

      if (respond) begin
         pready_d = 1'b1;
         if (r_write) begin
            pslverr_d = r_err;
         end else if (r_err) begin
            prdata_d  = '0;
            pslverr_d = 1'b1;
         end else begin
            prdata_d  = mem[r_idx];
            pslverr_d = 1'b0;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state   <= IDLE;
         wcnt    <= 2'd0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_d;
         wcnt    <= wcnt_d;
         PREADY  <= pready_d;
         PSLVERR <= pslverr_d;
         PRDATA  <= prdata_d;
         if (setup) begin
            idx_q   <= paddr_idx;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            err_q   <= setup_err;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (mem_we) begin
         mem[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with 0, 1 and 3 wait
// states share the bus signals and each has its own select.
module tb_apb_slave_mem;

   localparam int D0 = 0;  // WAIT_CYCLES = 0
   localparam int D1 = 1;  // WAIT_CYCLES = 1
   localparam int D3 = 2;  // WAIT_CYCLES = 3

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       PENABLE, PWRITE, PWAKEUP;
   logic [7:0] PADDR, PWDATA;
   logic       psel    [3];
   logic       pready  [3];
   logic       pslverr [3];
   logic [7:0] prdata  [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 PCLK = ~PCLK;

   apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(128), .WAIT_CYCLES(0)) u_w0 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWAKEUP(PWAKEUP),
      .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

   apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(128), .WAIT_CYCLES(1)) u_w1 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWAKEUP(PWAKEUP),
      .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

   apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(128), .WAIT_CYCLES(3)) u_w3 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWAKEUP(PWAKEUP),
      .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

   // Full transfer; bus values are scrambled during the access phase to show they are ignored.
   task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                       input logic [7:0] data, input logic wake,
                       output logic [7:0] rdata, output logic err, output int waits);
      bit done;
      done  = 1'b0;
      waits = 0;
      rdata = 'x;
      err   = 'x;
      psel[d] = 1'b1; PENABLE = 1'b0; PWRITE = wr;
      PADDR = addr; PWDATA = data; PWAKEUP = wake;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; PWRITE = !wr; PADDR = ~addr; PWDATA = ~data; PWAKEUP = !wake;
      for (int i = 0; i < 10 && !done; i++) begin
         @(negedge PCLK);
         if (pready[d] === 1'b1) begin
            rdata = prdata[d];
            err   = pslverr[d];
            done  = 1'b1;
         end else begin
            waits++;
         end
         @(posedge PCLK); #1;
      end
      psel[d] = 1'b0; PENABLE = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL xfer_timeout dut=%0d addr=%h: PREADY not seen within 10 cycles", d, addr);
      end
   endtask

   task automatic test_reset();
      PRESET = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PWAKEUP = 1'b1;
      for (int i = 0; i < 3; i++) psel[i] = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({pready[i], pslverr[i], prdata[i]} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut=%0d got ready=%b err=%b rdata=%h want 0 0 00",
                     i, pready[i], pslverr[i], prdata[i]);
         end
      end
      PRESET = 1'b0;
   endtask

   task automatic test_wait1_rw();
      logic [7:0] rd; logic er; int w;
      xfer(D1, 1'b1, 8'h10, 8'hA5, 1'b1, rd, er, w);
      n_checks++;
      if (w !== 1 || er !== 1'b0) begin
         n_fail++; $display("FAIL w1_write got waits=%0d err=%b want 1 0", w, er);
      end
      xfer(D1, 1'b0, 8'h10, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (rd !== 8'hA5 || er !== 1'b0 || w !== 1) begin
         n_fail++; $display("FAIL w1_read got rdata=%h err=%b waits=%0d want a5 0 1", rd, er, w);
      end
   endtask

   task automatic test_wait0_rw();
      logic [7:0] rd; logic er; int w;
      xfer(D0, 1'b1, 8'h00, 8'h3C, 1'b1, rd, er, w);
      n_checks++;
      if (w !== 0 || er !== 1'b0) begin
         n_fail++; $display("FAIL w0_write got waits=%0d err=%b want 0 0", w, er);
      end
      xfer(D0, 1'b0, 8'h00, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (rd !== 8'h3C || er !== 1'b0 || w !== 0) begin
         n_fail++; $display("FAIL w0_read got rdata=%h err=%b waits=%0d want 3c 0 0", rd, er, w);
      end
   endtask

   task automatic test_out_of_range();
      logic [7:0] rd; logic er; int w;
      xfer(D1, 1'b1, 8'h00, 8'h42, 1'b1, rd, er, w);
      xfer(D1, 1'b1, 8'h80, 8'hFF, 1'b1, rd, er, w);
      n_checks++;
      if (er !== 1'b1) begin
         n_fail++; $display("FAIL oor_write_err got %b want 1", er);
      end
      xfer(D1, 1'b0, 8'h80, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (er !== 1'b1 || rd !== 8'h00) begin
         n_fail++; $display("FAIL oor_read got err=%b rdata=%h want 1 00", er, rd);
      end
      xfer(D1, 1'b0, 8'h00, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (er !== 1'b0 || rd !== 8'h42) begin
         n_fail++; $display("FAIL oor_no_alias got err=%b rdata=%h want 0 42", er, rd);
      end
      xfer(D1, 1'b0, 8'h7F, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (er !== 1'b0 || rd !== 8'h00) begin
         n_fail++; $display("FAIL last_word_read got err=%b rdata=%h want 0 00", er, rd);
      end
   endtask

   task automatic test_wakeup();
      logic [7:0] rd; logic er; int w;
      xfer(D1, 1'b1, 8'h05, 8'h11, 1'b0, rd, er, w);
      n_checks++;
      if (er !== 1'b1) begin
         n_fail++; $display("FAIL wake_write_err got %b want 1", er);
      end
      xfer(D1, 1'b0, 8'h05, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (er !== 1'b0 || rd !== 8'h00) begin
         n_fail++; $display("FAIL wake_mem_untouched got err=%b rdata=%h want 0 00", er, rd);
      end
      xfer(D1, 1'b1, 8'h05, 8'h11, 1'b1, rd, er, w);
      xfer(D1, 1'b0, 8'h05, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (er !== 1'b0 || rd !== 8'h11) begin
         n_fail++; $display("FAIL wake_retry got err=%b rdata=%h want 0 11", er, rd);
      end
   endtask

   task automatic test_abort_wait3();
      logic [7:0] rd; logic er; int w; bit seen;
      seen = 1'b0;
      psel[D3] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h20; PWDATA = 8'h99; PWAKEUP = 1'b1;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK); if (pready[D3] !== 1'b0) seen = 1'b1;
      @(posedge PCLK); #1;
      psel[D3] = 1'b0; PENABLE = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK); if (pready[D3] !== 1'b0) seen = 1'b1;
      end
      @(posedge PCLK); #1;
      n_checks++;
      if (seen) begin
         n_fail++; $display("FAIL abort_no_ready got PREADY asserted want never");
      end
      xfer(D3, 1'b0, 8'h20, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (rd !== 8'h00 || er !== 1'b0 || w !== 3) begin
         n_fail++; $display("FAIL abort_read got rdata=%h err=%b waits=%0d want 00 0 3", rd, er, w);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd; logic er; int w;
      xfer(D1, 1'b1, 8'h30, 8'hC3, 1'b1, rd, er, w);
      n_checks++;
      if (pready[D1] !== 1'b0) begin
         n_fail++; $display("FAIL ready_single_cycle got %b want 0", pready[D1]);
      end
      xfer(D1, 1'b0, 8'h30, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (rd !== 8'hC3 || er !== 1'b0 || w !== 1) begin
         n_fail++; $display("FAIL b2b_read got rdata=%h err=%b waits=%0d want c3 0 1", rd, er, w);
      end
      xfer(D1, 1'b1, 8'h31, 8'h5E, 1'b0, rd, er, w);
      n_checks++;
      if (er !== 1'b1 || prdata[D1] !== 8'hC3) begin
         n_fail++; $display("FAIL write_keeps_prdata got err=%b prdata=%h want 1 c3", er, prdata[D1]);
      end
   endtask

   task automatic test_reset_midflight();
      logic [7:0] rd; logic er; int w;
      xfer(D3, 1'b1, 8'h07, 8'h5A, 1'b1, rd, er, w);
      xfer(D3, 1'b0, 8'h07, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (rd !== 8'h5A || w !== 3) begin
         n_fail++; $display("FAIL w3_read got rdata=%h waits=%0d want 5a 3", rd, w);
      end
      psel[D3] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h07; PWDATA = 8'h77; PWAKEUP = 1'b1;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      n_checks++;
      if ({pready[D3], pslverr[D3], prdata[D3]} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_midflight got ready=%b err=%b rdata=%h want 0 0 00",
                  pready[D3], pslverr[D3], prdata[D3]);
      end
      PRESET = 1'b0; psel[D3] = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      xfer(D3, 1'b0, 8'h07, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (rd !== 8'h00 || er !== 1'b0) begin
         n_fail++; $display("FAIL reset_clears_mem got rdata=%h err=%b want 00 0", rd, er);
      end
      xfer(D1, 1'b0, 8'h10, 8'h00, 1'b1, rd, er, w);
      n_checks++;
      if (rd !== 8'h00 || er !== 1'b0) begin
         n_fail++; $display("FAIL reset_clears_w1 got rdata=%h err=%b want 00 0", rd, er);
      end
   endtask

   initial begin
      test_reset();
      test_wait1_rw();
      test_wait0_rw();
      test_out_of_range();
      test_wakeup();
      test_abort_wait3();
      test_back_to_back();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
